// File: rtl/spike_generator_array.sv
`default_nettype none
// ============================================================================
// Module      : spike_generator_array
// Description : Bank of 2^NGENS programmable periodic spike generators. A
//               time-unit pulse triggers a sweep over generators
//               0..gens_used. Each due generator emits its tag with a count
//               of 1 on a valid/accept output channel.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_generator_array #(
  parameter int NGENS   = 8,
  parameter int NPERIOD = 16,
  parameter int NTAG    = 11,
  parameter int NCT     = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    time_unit_pulse,
  input  logic [NGENS-1:0]        gens_used,
  input  logic [(1<<NGENS)-1:0]   gens_en,
  input  logic [NGENS-1:0]        prog_gen_idx,
  input  logic [NPERIOD-1:0]      prog_period,
  input  logic [NPERIOD-1:0]      prog_ticks,
  input  logic [NTAG-1:0]         prog_tag,
  input  logic                    prog_v,
  output logic                    prog_a,
  output logic [NTAG-1:0]         out_tag,
  output logic [NCT-1:0]          out_ct,
  output logic                    out_v,
  input  logic                    out_a,
  output logic                    busy,
  output logic [15:0]             overrun_count
);

  localparam int c_NENT = 1 << NGENS;
  localparam int c_W    = 2 * NPERIOD + NTAG;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RD   = 3'd2,
    S_EV   = 3'd3,
    S_EMIT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NGENS-1:0]  idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [15:0]       overrun_q, overrun_d;
  logic              out_v_q, out_v_d;
  logic [NTAG-1:0]   out_tag_q, out_tag_d;

  // Entry layout: {period, ticks, tag}
  logic [c_W-1:0]    mem_q [c_NENT];
  logic [c_W-1:0]    rdata_q;

  logic              w_we;
  logic [NGENS-1:0]  w_waddr;
  logic [c_W-1:0]    w_wdata;
  logic              w_re;
  logic              w_clr;
  logic [NPERIOD-1:0] w_rp;
  logic [NPERIOD-1:0] w_rt;
  logic [NTAG-1:0]   w_rg;

  assign w_rp = rdata_q[c_W-1 -: NPERIOD];
  assign w_rt = rdata_q[NTAG +: NPERIOD];
  assign w_rg = rdata_q[NTAG-1:0];

  // Generator table: one write port, one read port with 1-cycle latency
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
    if (w_re) begin
      rdata_q <= mem_q[idx_q];
    end
  end

  // Sweep sequencing, table write-back, programming handshake, pending tracking
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    out_v_d   = out_v_q;
    out_tag_d = out_tag_q;
    w_we      = 1'b0;
    w_waddr   = idx_q;
    w_wdata   = '0;
    w_re      = 1'b0;
    w_clr     = 1'b0;
    prog_a    = 1'b0;

    case (state_q)
      S_INIT: begin
        w_we    = 1'b1;
        w_waddr = idx_q;
        w_wdata = '0;
        if (&idx_q) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + NGENS'(1);
        end
      end

      S_IDLE: begin
        if (pending_q) begin
          w_clr   = 1'b1;
          idx_d   = '0;
          state_d = S_RD;
        end else begin
          prog_a = prog_v;
          if (prog_v) begin
            w_we    = 1'b1;
            w_waddr = prog_gen_idx;
            w_wdata = {prog_period, prog_ticks, prog_tag};
          end
        end
      end

      S_RD: begin
        w_re    = 1'b1;
        state_d = S_EV;
      end

      S_EV: begin
        if (gens_en[idx_q] && (w_rp != '0) && (w_rt <= NPERIOD'(1))) begin
          // Due: reload the countdown and present the tag
          w_we      = 1'b1;
          w_waddr   = idx_q;
          w_wdata   = {w_rp, w_rp, w_rg};
          out_v_d   = 1'b1;
          out_tag_d = w_rg;
          state_d   = S_EMIT;
        end else begin
          if (gens_en[idx_q] && (w_rp != '0)) begin
            w_we    = 1'b1;
            w_waddr = idx_q;
            w_wdata = {w_rp, w_rt - NPERIOD'(1), w_rg};
          end
          if (idx_q == gens_used) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + NGENS'(1);
            state_d = S_RD;
          end
        end
      end

      S_EMIT: begin
        if (out_a) begin
          out_v_d = 1'b0;
          if (idx_q == gens_used) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + NGENS'(1);
            state_d = S_RD;
          end
        end
      end

      default: begin
        state_d = S_INIT;
        idx_d   = '0;
      end
    endcase

    // A pulse landing while a sweep is still owed is dropped and counted;
    // a pulse in the same cycle the owed sweep launches is a fresh request.
    if (w_clr) begin
      pending_d = 1'b0;
    end
    if (time_unit_pulse) begin
      if (pending_q && !w_clr && (overrun_q != 16'hFFFF)) begin
        overrun_d = overrun_q + 16'd1;
      end
      pending_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= '0;
      out_v_q   <= 1'b0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      out_v_q   <= out_v_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign out_v         = out_v_q;
  assign out_tag       = out_tag_q;
  assign out_ct        = NCT'(1);
  assign busy          = (state_q != S_IDLE) || pending_q;
  assign overrun_count = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_generator_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_generator_array
// Description : Scoreboard bench for spike_generator_array. Directed stimulus
//               pushes expected tags; a negedge monitor pops and compares on
//               every accepted output and checks hold-stability under stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_generator_array;

  logic           clk = 1'b0;
  logic           reset;
  logic           time_unit_pulse;
  logic [7:0]     gens_used;
  logic [255:0]   gens_en;
  logic [7:0]     prog_gen_idx;
  logic [15:0]    prog_period;
  logic [15:0]    prog_ticks;
  logic [10:0]    prog_tag;
  logic           prog_v;
  logic           prog_a;
  logic [10:0]    out_tag;
  logic [8:0]     out_ct;
  logic           out_v;
  logic           out_a;
  logic           busy;
  logic [15:0]    overrun_count;

  always #5 clk = ~clk;

  spike_generator_array dut (
    .clk             (clk),
    .reset           (reset),
    .time_unit_pulse (time_unit_pulse),
    .gens_used       (gens_used),
    .gens_en         (gens_en),
    .prog_gen_idx    (prog_gen_idx),
    .prog_period     (prog_period),
    .prog_ticks      (prog_ticks),
    .prog_tag        (prog_tag),
    .prog_v          (prog_v),
    .prog_a          (prog_a),
    .out_tag         (out_tag),
    .out_ct          (out_ct),
    .out_v           (out_v),
    .out_a           (out_a),
    .busy            (busy),
    .overrun_count   (overrun_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [10:0] sb [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare each accepted output against the scoreboard head
  logic        prev_v   = 1'b0;
  logic        prev_a   = 1'b0;
  logic [10:0] prev_tag = '0;
  logic [10:0] exp_tag;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_v && !prev_a) begin
        check("stall_hold_v", {31'b0, out_v}, 32'd1);
        check("stall_hold_tag", {21'b0, out_tag}, {21'b0, prev_tag});
      end
      if (out_v && out_a) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_out_v", {31'b0, out_v}, 32'd0);
        end else begin
          exp_tag = sb.pop_front();
          check("out_tag", {21'b0, out_tag}, {21'b0, exp_tag});
          check("out_ct", {23'b0, out_ct}, 32'd1);
        end
      end
    end
    prev_v   = out_v;
    prev_a   = out_a;
    prev_tag = out_tag;
  end

  task automatic program_gen(input int idx, input int per, input int tk, input int tag);
    int ok;
    @(posedge clk); #1;
    prog_gen_idx = idx[7:0];
    prog_period  = per[15:0];
    prog_ticks   = tk[15:0];
    prog_tag     = tag[10:0];
    prog_v       = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prog_a) begin
        ok = 1;
        break;
      end
    end
    check("prog_accept", ok, 1);
    @(posedge clk); #1;
    prog_v = 1'b0;
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    time_unit_pulse = 1'b1;
    @(posedge clk); #1;
    time_unit_pulse = 1'b0;
  endtask

  task automatic wait_quiet();
    int done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !out_v && sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("quiet_timeout", done, 1);
  endtask

  task automatic wait_out_v();
    int seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_v) begin
        seen = 1;
        break;
      end
    end
    check("out_v_timeout", seen, 1);
  endtask

  initial begin
    int cnt;
    int bad;
    int base;
    reset = 1'b1; time_unit_pulse = 1'b0;
    gens_used = '0; gens_en = '0;
    prog_gen_idx = '0; prog_period = '0; prog_ticks = '0; prog_tag = '0;
    prog_v = 1'b0; out_a = 1'b1;

    // Reset values and INIT duration
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_v", {31'b0, out_v}, 32'd0);
    check("rst_out_tag", {21'b0, out_tag}, 32'd0);
    check("rst_out_ct", {23'b0, out_ct}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_prog_a", {31'b0, prog_a}, 32'd0);
    check("rst_overrun", {16'b0, overrun_count}, 32'd0);
    prog_v = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (prog_a) bad++;
    end
    prog_v = 1'b0;
    check("init_busy_cycles", cnt, 256);
    check("init_prog_a_low", bad, 0);

    // Period 3 generator fires on pulses 1 and 4
    program_gen(3, 3, 1, 'h155);
    gens_used = 8'd3;
    gens_en = '0; gens_en[3] = 1'b1;
    out_a = 1'b1;
    for (int p = 1; p <= 6; p++) begin
      if (p == 1 || p == 4) sb.push_back(11'h155);
      pulse();
      repeat (20) @(posedge clk);
    end
    wait_quiet();
    check("t2_sb_left", sb.size(), 0);

    // Enable mask and ascending emission order
    program_gen(0, 1, 1, 'h010);
    program_gen(2, 1, 1, 'h020);
    gens_en = '0; gens_en[0] = 1'b1;
    sb.push_back(11'h010);
    pulse();
    wait_quiet();
    gens_en[2] = 1'b1;
    sb.push_back(11'h010);
    sb.push_back(11'h020);
    pulse();
    wait_quiet();
    check("t3_sb_left", sb.size(), 0);

    // Output stall, overruns, prog_a blocked during sweep
    program_gen(1, 1, 1, 'h031);
    gens_en = '0; gens_en[0] = 1'b1; gens_en[1] = 1'b1;
    gens_used = 8'd1;
    out_a = 1'b0;
    sb.push_back(11'h010); sb.push_back(11'h031);
    sb.push_back(11'h010); sb.push_back(11'h031);
    pulse();
    wait_out_v();
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(posedge clk);
      pulse();
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t4_stall_v", {31'b0, out_v}, 32'd1);
    check("t4_stall_tag", {21'b0, out_tag}, 32'h010);
    check("t4_overrun", {16'b0, overrun_count}, 32'd2);
    @(posedge clk); #1;
    prog_gen_idx = 8'd7; prog_period = '0; prog_ticks = '0; prog_tag = 11'h7FF;
    prog_v = 1'b1;
    out_a  = 1'b1;
    bad = 0; cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin
        cnt = 1;
        break;
      end
      if (prog_a) bad++;
    end
    check("t4_sweep_end", cnt, 1);
    check("t4_prog_a_blocked", bad, 0);
    check("t4_prog_a_idle", {31'b0, prog_a}, 32'd1);
    @(posedge clk); #1;
    prog_v = 1'b0;
    repeat (30) @(posedge clk);
    check("t4_sb_left", sb.size(), 0);

    // Reset during EMIT, then table is cleared
    out_a = 1'b0;
    pulse();
    wait_out_v();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_out_v_after_rst", {31'b0, out_v}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_a = 1'b1;
    gens_en = '1;
    gens_used = 8'd3;
    wait_quiet();
    check("t5_overrun_clr", {16'b0, overrun_count}, 32'd0);
    base = n_out;
    pulse();
    wait_quiet();
    repeat (20) @(posedge clk);
    check("t5_no_output", n_out - base, 0);
    program_gen(0, 1, 1, 'h077);
    sb.push_back(11'h077);
    pulse();
    wait_quiet();
    check("t5_reprog_output", n_out - base, 1);

    check("final_sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
